// File: rtl/gpio_ctrl_irq_pkg.sv
// gpio_ctrl_irq_pkg: shared mode encoding for the GPIO interrupt engine
package gpio_ctrl_irq_pkg;
  localparam int IRQ_MODE_W = 3;
  typedef enum logic [IRQ_MODE_W-1:0] {
    OFF    = 3'd0,
    RISE   = 3'd1,
    FALL   = 3'd2,
    BOTH   = 3'd3,
    LVL_HI = 3'd4,
    LVL_LO = 3'd5
  } irq_mode_e;
endpackage

// File: rtl/gpio_ctrl_debounce.sv
// gpio_ctrl_debounce: per-pin synchroniser, debounce counter, filtered value and edge event
module gpio_ctrl_debounce
  import gpio_ctrl_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic [DBNC_W-1:0] dbnc_cycles,
  output logic              filt,
  output logic              evt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBNC_W-1:0]      cnt;
  logic                   sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // The counter only advances while it is below the threshold, so it can never wrap.
  assign evt = (sync != filt) && (cnt >= dbnc_cycles);
  // Synchronise the pad, then accept a new level only after it has been stable past the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync == filt) cnt <= '0;
      else if (evt) begin
        filt <= sync;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/gpio_ctrl_irq_engine.sv
// gpio_ctrl_irq_engine: per-pin debounced interrupt engine with sticky W1C status (optional overrun via GPIO_CTRL_IRQ_OVERRUN_EN)
module gpio_ctrl_irq_engine
  import gpio_ctrl_irq_pkg::*;
#(
  parameter int NUM_PINS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PINS-1:0]            gpio_in,
  input  logic [NUM_PINS-1:0]            intr_enable,
  input  logic [IRQ_MODE_W*NUM_PINS-1:0] intr_mode,
  input  logic [DBNC_W-1:0]              dbnc_cycles,
  input  logic [NUM_PINS-1:0]            status_clr,
  output logic [NUM_PINS-1:0]            filt_data,
  output logic [NUM_PINS-1:0]            intr_status,
`ifdef GPIO_CTRL_IRQ_OVERRUN_EN
  output logic [NUM_PINS-1:0]            intr_overrun,
`endif
  output logic                           interrupt
);
  logic [NUM_PINS-1:0] evt;
  logic [NUM_PINS-1:0] set;
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_ctrl_debounce #(.SYNC_STAGES(SYNC_STAGES), .DBNC_W(DBNC_W)) u_dbnc (
      .clk(clk),
      .rst_n(rst_n),
      .din(gpio_in[g]),
      .dbnc_cycles(dbnc_cycles),
      .filt(filt_data[g]),
      .evt(evt[g])
    );
  end
  // Decode each pin's mode into a set request; at an event the new filtered value is the inverse of the current one.
  always_comb begin
    set = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      logic [IRQ_MODE_W-1:0] m;
      m = intr_mode[IRQ_MODE_W*i +: IRQ_MODE_W];
      set[i] = intr_enable[i] & (m == RISE   ? evt[i] & ~filt_data[i] :
                                 m == FALL   ? evt[i] &  filt_data[i] :
                                 m == BOTH   ? evt[i] :
                                 m == LVL_HI ? filt_data[i] :
                                 m == LVL_LO ? ~filt_data[i] : 1'b0);
    end
  end
  // Sticky status: a new set wins over a simultaneous clear strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intr_status <= '0;
    else intr_status <= set | (intr_status & ~status_clr);
  end
`ifdef GPIO_CTRL_IRQ_OVERRUN_EN
  // Overrun flags a second set arriving while status is still pending and not being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intr_overrun <= '0;
    else intr_overrun <= (set & intr_status & ~status_clr) | (intr_overrun & ~status_clr);
  end
`endif
  assign interrupt = |intr_status;
endmodule

// File: tb/tb_gpio_ctrl_irq_engine.sv
// tb_gpio_ctrl_irq_engine: scoreboard bench for the GPIO interrupt engine
module tb_gpio_ctrl_irq_engine;
  import gpio_ctrl_irq_pkg::*;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] gpio_in = '0, intr_enable = '0, status_clr = '0;
  logic [3*N-1:0] intr_mode = '0;
  logic [7:0] dbnc_cycles = '0;
  logic [N-1:0] filt_data, intr_status;
  logic interrupt;
`ifdef GPIO_CTRL_IRQ_OVERRUN_EN
  logic [N-1:0] intr_overrun;
`endif
  typedef struct {int due; int pin; logic f; logic s; logic irq; string name;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  gpio_ctrl_irq_engine #(.NUM_PINS(N), .SYNC_STAGES(2), .DBNC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .intr_enable(intr_enable),
    .intr_mode(intr_mode), .dbnc_cycles(dbnc_cycles), .status_clr(status_clr),
    .filt_data(filt_data), .intr_status(intr_status),
`ifdef GPIO_CTRL_IRQ_OVERRUN_EN
    .intr_overrun(intr_overrun),
`endif
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got cyc=%0d required completion", cyc);
    $fatal(1);
  end

  task automatic push(string name, int pin, int dly, logic f, logic s, logic irq);
    exp_t e;
    e.due = cyc + dly; e.pin = pin; e.f = f; e.s = s; e.irq = irq; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin
        checks++;
        if ({filt_data[q[i].pin], intr_status[q[i].pin], interrupt} !== {q[i].f, q[i].s, q[i].irq}) begin
          errors++;
          $display("FAIL %s pin%0d cyc%0d: got filt=%b status=%b irq=%b, expected filt=%b status=%b irq=%b",
                   q[i].name, q[i].pin, cyc, filt_data[q[i].pin], intr_status[q[i].pin], interrupt,
                   q[i].f, q[i].s, q[i].irq);
        end
        q.delete(i);
      end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic set_mode(int pin, logic [2:0] m);
    intr_mode[3*pin +: 3] = m;
  endtask

  task automatic clr_pulse(int pin);
    status_clr[pin] = 1'b1;
    tick();
    status_clr[pin] = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    gpio_in = '0; intr_enable = '0; status_clr = '0; intr_mode = '0; dbnc_cycles = '0;
    run(2);
    rst_n = 1'b1;
    run(1);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({filt_data, intr_status, interrupt} !== '0) begin
      errors++;
      $display("FAIL reset: got filt=%h status=%h irq=%b, expected all 0", filt_data, intr_status, interrupt);
    end
    gpio_in = '0;
    intr_enable = '1;
    push("reset_idle", 1, 4, 1'b0, 1'b0, 1'b0);
    run(4);
  endtask

  task automatic test_rise();
    reset_dut();
    set_mode(3, RISE);
    intr_enable[3] = 1'b1;
    gpio_in[3] = 1'b1;
    push("rise_before", 3, 2, 1'b0, 1'b0, 1'b0);
    push("rise_edge", 3, 3, 1'b1, 1'b1, 1'b1);
    run(3);
    push("rise_clear", 3, 1, 1'b1, 1'b0, 1'b0);
    clr_pulse(3);
  endtask

  task automatic test_debounce();
    reset_dut();
    dbnc_cycles = 8'd4;
    set_mode(5, BOTH);
    intr_enable[5] = 1'b1;
    gpio_in[5] = 1'b1;
    run(3);
    gpio_in[5] = 1'b0;
    push("glitch", 5, 8, 1'b0, 1'b0, 1'b0);
    run(10);
    gpio_in[5] = 1'b1;
    push("dbnc_before", 5, 6, 1'b0, 1'b0, 1'b0);
    push("dbnc_rise", 5, 7, 1'b1, 1'b1, 1'b1);
    run(5);
    gpio_in[5] = 1'b0;
    run(2);
    push("dbnc_clear", 5, 1, 1'b1, 1'b0, 1'b0);
    clr_pulse(5);
    push("fall_before", 5, 3, 1'b1, 1'b0, 1'b0);
    push("fall_edge", 5, 4, 1'b0, 1'b1, 1'b1);
    run(4);
  endtask

  task automatic test_level();
    reset_dut();
    set_mode(0, LVL_HI);
    intr_enable[0] = 1'b1;
    gpio_in[0] = 1'b1;
    push("lvl_set", 0, 5, 1'b1, 1'b1, 1'b1);
    run(5);
    push("lvl_clr_held", 0, 1, 1'b1, 1'b1, 1'b1);
    clr_pulse(0);
    gpio_in[0] = 1'b0;
    push("lvl_sticky", 0, 6, 1'b0, 1'b1, 1'b1);
    run(6);
    push("lvl_clr_sticks", 0, 1, 1'b0, 1'b0, 1'b0);
    clr_pulse(0);
  endtask

  task automatic test_set_wins();
    reset_dut();
    set_mode(7, RISE);
    intr_enable[7] = 1'b1;
    gpio_in[7] = 1'b1;
    run(2);
    push("set_wins", 7, 1, 1'b1, 1'b1, 1'b1);
    clr_pulse(7);
    push("set_wins_hold", 7, 1, 1'b1, 1'b1, 1'b1);
    run(1);
    set_mode(8, 3'd6);
    intr_enable[8] = 1'b1;
    set_mode(9, RISE);
    intr_enable[9] = 1'b0;
    gpio_in[8] = 1'b1; gpio_in[9] = 1'b1;
    push("reserved_hi", 8, 3, 1'b1, 1'b0, 1'b1);
    push("disabled_hi", 9, 3, 1'b1, 1'b0, 1'b1);
    run(4);
    gpio_in[8] = 1'b0; gpio_in[9] = 1'b0;
    push("reserved_lo", 8, 3, 1'b0, 1'b0, 1'b1);
    push("disabled_lo", 9, 3, 1'b0, 1'b0, 1'b1);
    run(4);
  endtask

  task automatic test_reset_mid();
    reset_dut();
    dbnc_cycles = 8'd10;
    set_mode(2, RISE);
    intr_enable[2] = 1'b1;
    gpio_in[2] = 1'b1;
    push("mid_count", 2, 7, 1'b0, 1'b0, 1'b0);
    run(7);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({filt_data, intr_status, interrupt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got filt=%h status=%h irq=%b, expected all 0", filt_data, intr_status, interrupt);
    end
    run(2);
    rst_n = 1'b1;
    push("post_rst_before", 2, 12, 1'b0, 1'b0, 1'b0);
    push("post_rst_rise", 2, 13, 1'b1, 1'b1, 1'b1);
    run(13);
  endtask

  task automatic test_overrun();
`ifdef GPIO_CTRL_IRQ_OVERRUN_EN
    reset_dut();
    set_mode(4, BOTH);
    intr_enable[4] = 1'b1;
    gpio_in[4] = 1'b1;
    run(3);
    checks++;
    if ({intr_status[4], intr_overrun[4]} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_first: got status=%b ovr=%b, expected status=1 ovr=0", intr_status[4], intr_overrun[4]);
    end
    gpio_in[4] = 1'b0;
    run(3);
    checks++;
    if ({intr_status[4], intr_overrun[4]} !== 2'b11) begin
      errors++;
      $display("FAIL ovr_second: got status=%b ovr=%b, expected status=1 ovr=1", intr_status[4], intr_overrun[4]);
    end
    clr_pulse(4);
    checks++;
    if ({intr_status[4], intr_overrun[4]} !== 2'b00) begin
      errors++;
      $display("FAIL ovr_clear: got status=%b ovr=%b, expected status=0 ovr=0", intr_status[4], intr_overrun[4]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rise();
    test_debounce();
    test_level();
    test_set_wins();
    test_reset_mid();
    test_overrun();
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL scoreboard: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl_irq_engine.md
Name: gpio_ctrl_irq_engine

Overview:
Parametrised, per-pin interrupt engine for the GPIO controller. It replaces the fixed 256-pin, 8-group edge logic with the following:
- configurable pin count and synchroniser depth
- a programmable debounce filter
- per-pin mode selection: rising, falling, both-edge, level-high or level-low
- per-pin sticky status with write-1-to-clear

It sits between the raw GPIO input pads and the CSR block. CSR fields drive the mode, enable, clear and debounce inputs; the status outputs feed CSR read-back and the interrupt line.

Parameters:
NUM_PINS, 32, number of GPIO pins handled (1..256)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DBNC_W, 8, width of the debounce threshold and per-pin counters

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
gpio_in  input  NUM_PINS  raw asynchronous pad inputs
intr_enable  input  NUM_PINS  per-pin enable; status can only set while this is 1
intr_mode  input  3*NUM_PINS  per-pin mode; pin i uses [3i+:3]
dbnc_cycles  input  DBNC_W  global debounce threshold D
status_clr  input  NUM_PINS  one-cycle W1C clear strobes from the CSR block
filt_data  output  NUM_PINS  debounced input value, read back as input data
intr_status  output  NUM_PINS  sticky per-pin status
interrupt  output  1  OR of all intr_status bits

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous and active-low. All flops clear to 0 on reset:
  - sync chain, filt_data, counters, intr_status
  - interrupt therefore resets to 0
- Sync: gpio_in passes through SYNC_STAGES flops per pin, giving sync[i].
- Debounce, per pin, each cycle:
  - if sync==filt: cnt<=0
  - else if cnt>=D: filt<=sync, cnt<=0, and an event is flagged this cycle
  - else: cnt<=cnt+1
- Debounce consequences:
  - D=0 means no filtering.
  - A glitch shorter than D+1 cycles is discarded and the counter resets.
  - Lowering D mid-count takes effect immediately (>= compare).
  - The counter never wraps; its maximum reached value is D.
- Latency, input change to filt/status update: SYNC_STAGES+D+1 clock edges.
- Mode encoding:
  - 0 = off
  - 1 = rise (event with new filt=1)
  - 2 = fall (event with new filt=0)
  - 3 = both
  - 4 = level-high (filt==1)
  - 5 = level-low (filt==0)
  - 6 and 7 = reserved, treated as off
- Status:
  - set_i = intr_enable[i] & mode condition.
  - Next status = set_i | (status & ~status_clr).
  - Set wins over a simultaneous clear.
  - Level modes re-set every cycle while the condition holds, so a clear only sticks once the level deasserts or the pin is disabled.
- Disabling a pin, or changing its mode, does not clear existing status.
- interrupt = |intr_status, combinational from flops, glitch-free.
- After reset filt=0, so a pin held high produces a rising event after the normal latency.
- Reset mid-debounce discards the count.

Optional Feature:
- Macro: GPIO_CTRL_IRQ_OVERRUN_EN.
- When defined:
  - adds output port intr_overrun (NUM_PINS, reset 0)
  - intr_overrun[i] sets when set_i occurs while intr_status[i] is already 1 and status_clr[i]=0
  - intr_overrun[i] clears with the same status_clr[i] strobe (set wins)
- When undefined: the port and its flops are absent; behaviour is otherwise identical.

Decomposition:
- Package gpio_ctrl_irq_pkg holds:
  - enum irq_mode_e (OFF, RISE, FALL, BOTH, LVL_HI, LVL_LO)
  - constant IRQ_MODE_W=3
- One sub-module, gpio_ctrl_debounce:
  - contains sync chain, counter, filt and event for a single pin
  - parameters SYNC_STAGES and DBNC_W
  - instantiated NUM_PINS times in a generate loop
- Status, mode decode and the OR-reduce stay in the top.

Test Plan:
1. D=0, pin3 mode RISE, enabled; gpio_in[3] 0->1 -> filt_data[3] and intr_status[3] rise exactly 3 edges later (SYNC_STAGES=2); interrupt=1; status_clr[3] pulse -> status 0 the next cycle.
2. D=4, mode BOTH; 3-cycle high glitch -> no filt change, no status. 5-cycle high pulse -> status set 7 edges after the rise; after clear, the fall sets status again.
3. Pin0 LVL_HI with input held high; status_clr pulse -> status remains 1. Drop input -> clear then sticks; interrupt=0.
4. Event and status_clr in the same cycle -> status stays 1. Mode 6 or enable=0 with edges -> status never sets.
5. Assert rst_n=0 mid-count (D=10, cnt=5) -> all outputs 0 immediately. After release, an input held at 1 yields a rising event after 2+10+1 edges.
6. With GPIO_CTRL_IRQ_OVERRUN_EN: two rising events without a clear -> intr_overrun[i]=1; one clear -> both bits 0. NUM_PINS=1 and NUM_PINS=256 builds both elaborate.
